// File: rtl/sipo_rx_if.sv
// sipo_rx_if: serial input and parallel-output handshake bundle for sipo_rx.
interface sipo_rx_if #(parameter int WIDTH = 4);
  logic sin;
  logic sin_valid;
  logic start;
  logic [WIDTH-1:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic busy;
  logic overrun;
  modport master (output sin, sin_valid, start, dout_ready, input dout, dout_valid, busy, overrun);
  modport slave (input sin, sin_valid, start, dout_ready, output dout, dout_valid, busy, overrun);
endinterface

// File: rtl/sipo_rx.sv
// sipo_rx: MSB-first serial-to-parallel receiver with valid/ready output and overrun pulse.
module sipo_rx #(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  sipo_rx_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0] state;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dout_r;
  logic dout_valid_r;
  logic overrun_r;
  logic last;
  logic [WIDTH-1:0] word;
  assign word = {sr[WIDTH-2:0], bus.sin};
  assign last = state == SHIFT && bus.sin_valid && !bus.start && cnt == CNT_W'(WIDTH - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      dout_r <= '0;
      dout_valid_r <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (bus.sin_valid && bus.start) begin
        state <= SHIFT;
        sr <= {{(WIDTH-1){1'b0}}, bus.sin};
        cnt <= CNT_W'(1);
      end else if (bus.sin_valid && state == SHIFT) begin
        sr <= word;
        cnt <= last ? '0 : cnt + CNT_W'(1);
        state <= last ? IDLE : SHIFT;
      end
      // a completed word is only taken if the register is free or being drained this edge
      overrun_r <= last && dout_valid_r && !bus.dout_ready;
      if (last && (!dout_valid_r || bus.dout_ready)) begin
        dout_r <= word;
        dout_valid_r <= 1'b1;
      end else if (dout_valid_r && bus.dout_ready) begin
        dout_valid_r <= 1'b0;
      end
    end
  end
  assign bus.dout = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign bus.busy = state == SHIFT;
  assign bus.overrun = overrun_r;
endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: table-driven frames plus hand sequences; a queue scoreboard checks every accepted word.
module tb_sipo_rx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  sipo_rx_if #(.WIDTH(4)) bus();
  sipo_rx #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [3:0] bits;
    int gap;
    logic [3:0] exp_dout;
  } vec_t;
  vec_t vecs [6];
  int tests = 0;
  int fails = 0;
  logic [3:0] q [$];
  logic [3:0] exp_w;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic s, input logic b, input logic r);
    bus.sin_valid = v;
    bus.start = s;
    bus.sin = b;
    bus.dout_ready = r;
    @(posedge clk);
    #1;
  endtask
  task automatic send_frame(input logic [3:0] bits, input int gap, input logic rb, input logic rl, input logic pushw);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && pushw) q.push_back(bits);
      drive(1'b1, i == 0, bits[3-i], i == 3 ? rl : rb);
      check("busy", 32'(bus.busy), 32'(i < 3));
      if (i < 3) repeat (gap) drive(1'b0, 1'b0, 1'b0, rb);
    end
  endtask
  always @(negedge clk) begin
    if (reset && bus.dout_valid && bus.dout_ready) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL sb_extra: got %0h expected no word", bus.dout);
      end else begin
        exp_w = q.pop_front();
        if (bus.dout !== exp_w) begin
          fails++;
          $display("FAIL sb_word: got %0h expected %0h", bus.dout, exp_w);
        end
      end
    end
  end
  initial begin
    vecs[0] = '{4'b1011, 0, 4'b1011};
    vecs[1] = '{4'b0110, 2, 4'b0110};
    vecs[2] = '{4'b0000, 1, 4'b0000};
    vecs[3] = '{4'b1111, 0, 4'b1111};
    vecs[4] = '{4'b1000, 3, 4'b1000};
    vecs[5] = '{4'b0001, 0, 4'b0001};
    bus.sin = 1'b0;
    bus.sin_valid = 1'b0;
    bus.start = 1'b0;
    bus.dout_ready = 1'b1;
    #12;
    check("rst_dout", 32'(bus.dout), 0);
    check("rst_valid", 32'(bus.dout_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_overrun", 32'(bus.overrun), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    check("ignored_busy", 32'(bus.busy), 0);
    check("ignored_valid", 32'(bus.dout_valid), 0);
    foreach (vecs[k]) begin
      send_frame(vecs[k].bits, vecs[k].gap, 1'b1, 1'b1, 1'b1);
      check("tbl_dout", 32'(bus.dout), 32'(vecs[k].exp_dout));
      check("tbl_valid", 32'(bus.dout_valid), 1);
      check("tbl_overrun", 32'(bus.overrun), 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check("tbl_valid_drop", 32'(bus.dout_valid), 0);
      check("tbl_dout_hold", 32'(bus.dout), 32'(vecs[k].exp_dout));
    end
    send_frame(4'b1001, 0, 1'b0, 1'b0, 1'b1);
    check("ovr_first", 32'(bus.dout), 32'h9);
    send_frame(4'b0110, 0, 1'b0, 1'b0, 1'b0);
    check("ovr_dout", 32'(bus.dout), 32'h9);
    check("ovr_valid", 32'(bus.dout_valid), 1);
    check("ovr_pulse", 32'(bus.overrun), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_pulse_end", 32'(bus.overrun), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr_drain_valid", 32'(bus.dout_valid), 0);
    check("ovr_drain_dout", 32'(bus.dout), 32'h9);
    send_frame(4'b1001, 0, 1'b0, 1'b0, 1'b1);
    send_frame(4'b0101, 0, 1'b0, 1'b1, 1'b1);
    check("simul_dout", 32'(bus.dout), 32'h5);
    check("simul_valid", 32'(bus.dout_valid), 1);
    check("simul_overrun", 32'(bus.overrun), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("simul_drop", 32'(bus.dout_valid), 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    check("resync_busy", 32'(bus.busy), 1);
    send_frame(4'b0010, 0, 1'b1, 1'b1, 1'b1);
    check("resync_dout", 32'(bus.dout), 32'h2);
    check("resync_overrun", 32'(bus.overrun), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("resync_drop", 32'(bus.dout_valid), 0);
    send_frame(4'b1100, 0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("pre_rst_valid", 32'(bus.dout_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_dout", 32'(bus.dout), 0);
    check("async_valid", 32'(bus.dout_valid), 0);
    check("async_busy", 32'(bus.busy), 0);
    bus.sin_valid = 1'b0;
    bus.start = 1'b0;
    #10;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_frame(4'b1110, 0, 1'b1, 1'b1, 1'b1);
    check("post_rst_dout", 32'(bus.dout), 32'he);
    check("post_rst_valid", 32'(bus.dout_valid), 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("sb_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
